// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: constants and helpers shared by the SRAM port arbiter files
package sram_arb_pkg;
  localparam int SRAM_RD_LATENCY = 2;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after last_grant, with lock override
module rr_arbiter import sram_arb_pkg::*; #(
  parameter int N  = 3,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic          i_lock_valid,
  input  logic [IW-1:0] i_lock_idx,
  input  logic [IW-1:0] i_last_grant,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [IW:0] w_dist;
  logic [IW:0] w_best;
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    w_dist = '0;
    w_best = (IW+1)'(N);
    // distance 0 is the slot right after last_grant; the nearest requester wins
    for (int j = 0; j < N; j++) begin
      w_dist = (IW+1)'((j + 2*N - 1 - int'(i_last_grant)) % N);
      if (i_req[j] && w_dist < w_best) begin
        w_best = w_dist;
        o_idx  = IW'(j);
      end
    end
    if (i_lock_valid && i_req[i_lock_idx]) o_idx = i_lock_idx;
    if (|i_req) o_gnt[o_idx] = 1'b1;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between requesters with round-robin, lock and tagged read return
module sram_port_arbiter import sram_arb_pkg::*; #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ-1:0]            i_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic                          o_mem_we,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_data,
  input  logic [DATA_WIDTH-1:0]         i_mem_q
);
  localparam int IW = idx_width(NUM_REQ);
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_acc;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      r_lock_idx;
  logic               r_lock_valid;
  logic               r_tv [SRAM_RD_LATENCY];
  logic [IW-1:0]      r_ti [SRAM_RD_LATENCY];
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_req        (i_req),
    .i_lock_valid (r_lock_valid),
    .i_lock_idx   (r_lock_idx),
    .i_last_grant (r_last),
    .o_gnt        (w_gnt),
    .o_idx        (w_idx)
  );
  assign o_gnt    = i_rst_n ? w_gnt : '0;
  assign w_acc    = |(o_gnt & i_req);
  assign o_rvalid = r_tv[SRAM_RD_LATENCY-1] ? NUM_REQ'(1) << r_ti[SRAM_RD_LATENCY-1] : '0;
  assign o_rdata  = i_mem_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last       <= IW'(NUM_REQ-1);
      r_lock_valid <= 1'b0;
      r_lock_idx   <= '0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      for (int i = 0; i < SRAM_RD_LATENCY; i++) begin
        r_tv[i] <= 1'b0;
        r_ti[i] <= '0;
      end
    end else begin
      r_lock_valid <= w_acc && i_lock[w_idx];
      o_mem_we     <= w_acc && i_we[w_idx];
      if (w_acc) begin
        r_last     <= w_idx;
        r_lock_idx <= w_idx;
        o_mem_addr <= i_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        o_mem_data <= i_wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
      // tag pipeline mirrors the SRAM read latency so rvalid lines up with mem_q
      r_tv[0] <= w_acc && !i_we[w_idx];
      r_ti[0] <= w_idx;
      for (int i = 1; i < SRAM_RD_LATENCY; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_ti[i] <= r_ti[i-1];
      end
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random checks of the arbiter against a rule-level model
module tb_sram_port_arbiter;
  localparam int N = 3, AW = 6, DW = 8, MAXC = 2048;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, we = '0, lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] sram [64];
  logic [DW-1:0] shadow [64];
  bit [N-1:0] exp_rv [MAXC];
  logic [DW-1:0] exp_rd [MAXC];
  int errors = 0, checks = 0, cyc = 0, last = N-1, lk_i = 0, acc_k = -1;
  bit lk_v = 0;
  logic e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  sram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_lock(lock),
    .i_addr(addr), .i_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_data(mem_data), .i_mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we === 1'b1) sram[mem_addr] <= mem_data;
    mem_q <= sram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic set_a(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic step();
    logic [N-1:0] eg;
    int k;
    #1;
    eg = '0;
    k = -1;
    if (rst_n) begin
      if (lk_v && req[lk_i]) k = lk_i;
      else for (int d = 1; d <= N; d++) if (k < 0 && req[(last + d) % N]) k = (last + d) % N;
    end
    if (k >= 0) eg[k] = 1'b1;
    acc_k = k;
    chk("gnt", 32'(gnt), 32'(eg));
    if (rst_n) begin
      chk("rvalid", 32'(rvalid), 32'(exp_rv[cyc]));
      if (exp_rv[cyc] != 0) chk("rdata", 32'(rdata), 32'(exp_rd[cyc]));
      lk_v = (k >= 0) && lock[k];
      e_we = 1'b0;
      if (k >= 0) begin
        last = k;
        lk_i = k;
        e_we = we[k];
        e_addr = addr[k*AW +: AW];
        e_data = wdata[k*DW +: DW];
        if (we[k]) shadow[e_addr] = e_data;
        else begin
          exp_rv[cyc+2] = eg;
          exp_rd[cyc+2] = shadow[e_addr];
        end
      end
    end else begin
      last = N-1;
      lk_v = 0;
      e_we = 1'b0;
      e_addr = '0;
      e_data = '0;
      exp_rv[cyc+1] = '0;
      exp_rv[cyc+2] = '0;
    end
    @(posedge clk);
    #1;
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_data", 32'(mem_data), 32'(e_data));
    cyc++;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 64; i++) begin
      sram[i] = 8'($urandom);
      shadow[i] = sram[i];
    end
    step();
    step();
    rst_n = 1'b1;
    req = 3'b001; we = 3'b001; set_a(0, 6'd5, 8'hA5);
    step();
    req = 3'b000; we = '0;
    step();
    req = 3'b010; set_a(1, 6'd5, 8'h00);
    step();
    req = 3'b000;
    step();
    chk("rd_a5", 32'(rdata), 32'h0A5);
    step();
    req = 3'b111; we = '0;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) set_a(i, 6'($urandom), 8'h00);
      step();
    end
    req = 3'b000;
    step();
    step();
    cnt = 0;
    req = 3'b100; lock = 3'b100; set_a(2, 6'd0, 8'h00);
    for (int t = 0; t < 8; t++) begin
      step();
      if (acc_k == 2) cnt++;
      req = (cnt < 4) ? 3'b111 : 3'b011;
      lock = (cnt < 3) ? 3'b100 : 3'b000;
      set_a(2, 6'(cnt), 8'h00);
    end
    req = 3'b000; lock = '0;
    step();
    step();
    req = 3'b001; we = 3'b001; set_a(0, 6'd9, 8'h3C);
    step();
    req = 3'b010; we = 3'b000; set_a(1, 6'd9, 8'h00);
    step();
    req = 3'b000;
    step();
    chk("raw_3c", 32'(rdata), 32'h03C);
    step();
    step();
    req = 3'b011; we = '0; set_a(0, 6'd1, 8'h00); set_a(1, 6'd2, 8'h00);
    step();
    step();
    rst_n = 1'b0; req = 3'b001; we = 3'b001;
    step();
    rst_n = 1'b1; req = '0; we = '0;
    step();
    step();
    req = 3'b111;
    step();
    chk("post_rst_first", 32'(acc_k), 32'd0);
    for (int t = 0; t < 400; t++) begin
      req = 3'($urandom);
      we = 3'($urandom);
      lock = 3'($urandom & $urandom);
      for (int i = 0; i < N; i++) set_a(i, 6'($urandom), 8'($urandom));
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1; req = '0;
    step();
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
